ddr_bank_scheduler: RTL
=======================

Name: ddr_bank_scheduler

Overview:
- Triple-buffer frame-bank scheduler for the DDR frame store.
- Decides which DDR bank (address bits [24:23]) the camera-side writer fills and which bank the VGA/Ethernet-side reader drains.
- Issues one-cycle wr_load/rd_load pulses with the new bank numbers to the DDR read/write address controller, and consumes that controller's frame_wr_done/frame_rd_done levels.
- Guarantees the reader never sits on the bank being written; drops stale frames and repeats frames when rates differ.

Parameters:
- NUM_BANKS, 3: number of frame banks in rotation. Legal values 3 or 4.
- WR_BANK_INIT, 2'd0: writer bank after reset.
- RD_BANK_INIT, 2'd1: reader bank after reset. Must differ from WR_BANK_INIT.
- CNT_W, 16: width of the drop and repeat statistic counters.

Ports:
- DDR_CLK  in  1  single clock for all logic.
- DDR_RST  in  1  reset, asynchronous, active-high.
- frame_wr_done  in  1  level from the write controller; held high from end of frame until the wr_load is seen.
- frame_rd_done  in  1  level from the read controller; high while the read address sits at end of frame.
- rd_hold  in  1  freeze request: the reader keeps its current bank (snapshot mode).
- wr_bank  out  2  bank the writer must use.
- wr_load  out  1  one-cycle pulse; the writer reloads its address from wr_bank.
- rd_bank  out  2  bank the reader must use.
- rd_load  out  1  one-cycle pulse; the reader reloads its address from rd_bank.
- frame_valid  out  1  sticky; set on the first completed write frame.
- drop_cnt  out  CNT_W  count of ready frames overwritten before being read (saturating).
- repeat_cnt  out  CNT_W  count of reader frames replayed because no new frame was ready (saturating).

Behaviour:
- Reset values: wr_bank=WR_BANK_INIT, rd_bank=RD_BANK_INIT, wr_load=0, rd_load=0, frame_valid=0, drop_cnt=0, repeat_cnt=0.
- Internal reset values: ready_valid=0, ready_bank=0, edge-history registers wr_d=1 and rd_d=1.
  - Because the history registers reset to 1, a done level already high when reset releases is not an edge.
- Edge detection: wr_evt = frame_wr_done & ~wr_d; rd_evt = frame_rd_done & ~rd_d & frame_valid. History registers update every clock.
- Latency: all outputs are registered. Bank changes and load pulses appear the clock after the first clock edge at which the done level is sampled high. Each pulse is exactly 1 cycle; load is 0 in every other cycle.
- Write event only:
  - If ready_valid=1, drop_cnt++.
  - ready_bank<=wr_bank; ready_valid<=1; frame_valid<=1.
  - wr_bank<=lowest index in [0,NUM_BANKS-1] not equal to rd_bank and not equal to the old wr_bank.
  - wr_load<=1.
- Read event only, rd_hold=0, ready_valid=1: rd_bank<=ready_bank; ready_valid<=0; rd_load<=1.
- Read event only, rd_hold=0, ready_valid=0: rd_bank unchanged; rd_load<=1; repeat_cnt++.
- Read event only, rd_hold=1: rd_bank unchanged; rd_load<=1; ready frame kept; no counter change.
- Simultaneous write and read events (same cycle):
  - The write side completes first (drop check against the old ready_valid included).
  - If rd_hold=0, the reader takes the just-finished bank: rd_bank<=old wr_bank; ready_valid<=0; no repeat count.
  - New wr_bank = lowest index not equal to the new rd_bank and not equal to the new ready_bank when ready_valid stays 1.
  - Both wr_load and rd_load pulse in the same cycle.
- Invariant, checked by assertion: wr_bank != rd_bank at all times. When ready_valid=1, ready_bank differs from both.
- Read events before frame_valid=1 are ignored: no rd_load, no count.
- Counters saturate at all-ones.
- DDR_RST mid-frame: immediate return to the reset values. Any pending pulse is cancelled.

Test Plan:
- Reset with frame_wr_done held at 1, then release, then hold 5 cycles -> no wr_load; wr_bank=0, rd_bank=1.
- Reset released, then frame_wr_done rises -> next cycle: wr_load=1 for exactly 1 cycle, wr_bank=2, frame_valid=1. A later frame_rd_done rise -> rd_load=1 with rd_bank=0.
- Two write frames with no read in between (wr 0->2->0 with rd_bank=1) -> drop_cnt=1. Each wr_load selects a bank other than 1 and other than the held ready bank.
- After one read consumes the ready frame, a second frame_rd_done with no new write -> rd_load=1, rd_bank unchanged, repeat_cnt=1.
- frame_wr_done and frame_rd_done rise in the same cycle (wr_bank=2, rd_bank=0) -> next cycle: rd_bank=2, wr_bank=0, both loads =1, drop_cnt and repeat_cnt unchanged.
- rd_hold=1 across 3 read events while writes continue -> rd_bank constant, 3 rd_load pulses, wr_bank never equals rd_bank. Force 65536 drops -> drop_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/ddr_bank_scheduler_if.sv
// Bank-scheduler bus: done levels and hold request in, bank numbers, load pulses
// and frame statistics out. The dbg_* signals expose the internal ready-frame state.
interface ddr_bank_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             frame_wr_done;
  logic             frame_rd_done;
  logic             rd_hold;
  logic [1:0]       wr_bank;
  logic             wr_load;
  logic [1:0]       rd_bank;
  logic             rd_load;
  logic             frame_valid;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] repeat_cnt;
  logic             dbg_ready_valid;
  logic [1:0]       dbg_ready_bank;

  // Handshake: there is no ready/back-pressure. The done inputs are levels, and
  // only their rising edges count. wr_load/rd_load are single-cycle strobes that
  // the address controller must accept in the cycle they are high.
  modport master (
    output frame_wr_done, frame_rd_done, rd_hold,
    input  wr_bank, wr_load, rd_bank, rd_load, frame_valid, drop_cnt, repeat_cnt,
    input  dbg_ready_valid, dbg_ready_bank
  );

  modport slave (
    input  frame_wr_done, frame_rd_done, rd_hold,
    output wr_bank, wr_load, rd_bank, rd_load, frame_valid, drop_cnt, repeat_cnt,
    output dbg_ready_valid, dbg_ready_bank
  );
endinterface

// File: rtl/ddr_bank_scheduler.sv
// Triple/quad-buffer frame-bank scheduler: rotates writer and reader banks so the
// reader never sits on the bank being written, dropping or repeating frames as needed.
module ddr_bank_scheduler #(
  parameter int         NUM_BANKS    = 3,
  parameter logic [1:0] WR_BANK_INIT = 2'd0,
  parameter logic [1:0] RD_BANK_INIT = 2'd1,
  parameter int         CNT_W        = 16
) (
  input  logic                 DDR_CLK,
  input  logic                 DDR_RST,
  ddr_bank_scheduler_if.slave  bus
);

  logic [1:0]       wr_bank_q, rd_bank_q, ready_bank_q;
  logic             ready_valid_q, frame_valid_q;
  logic             wr_load_q, rd_load_q;
  logic             wr_d, rd_d;
  logic [CNT_W-1:0] drop_q, repeat_q;

  logic [1:0]       wr_bank_n, rd_bank_n, ready_bank_n;
  logic             ready_valid_n, frame_valid_n;
  logic             wr_load_n, rd_load_n;
  logic             drop_inc, repeat_inc;
  logic             wr_evt, rd_evt;

  // Lowest bank index in rotation that differs from both a and b.
  function automatic logic [1:0] pick_bank(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (2'(i) != a && 2'(i) != b) r = 2'(i);
    end
    return r;
  endfunction

  assign wr_evt = bus.frame_wr_done & ~wr_d;
  assign rd_evt = bus.frame_rd_done & ~rd_d & frame_valid_q;

  always_comb begin
    wr_bank_n     = wr_bank_q;
    rd_bank_n     = rd_bank_q;
    ready_bank_n  = ready_bank_q;
    ready_valid_n = ready_valid_q;
    frame_valid_n = frame_valid_q;
    wr_load_n     = 1'b0;
    rd_load_n     = 1'b0;
    drop_inc      = 1'b0;
    repeat_inc    = 1'b0;

    // Writer completes first, so a simultaneous read sees the just-finished bank.
    if (wr_evt) begin
      drop_inc      = ready_valid_q;
      ready_bank_n  = wr_bank_q;
      ready_valid_n = 1'b1;
      frame_valid_n = 1'b1;
      wr_load_n     = 1'b1;
    end

    if (rd_evt) begin
      rd_load_n = 1'b1;
      if (!bus.rd_hold) begin
        if (wr_evt) begin
          rd_bank_n     = wr_bank_q;
          ready_valid_n = 1'b0;
        end else if (ready_valid_q) begin
          rd_bank_n     = ready_bank_q;
          ready_valid_n = 1'b0;
        end else begin
          repeat_inc = 1'b1;
        end
      end
    end

    if (wr_evt) begin
      wr_bank_n = pick_bank(rd_bank_n, ready_valid_n ? ready_bank_n : rd_bank_n);
    end
  end

  always_ff @(posedge DDR_CLK or posedge DDR_RST) begin
    if (DDR_RST) begin
      wr_bank_q     <= WR_BANK_INIT;
      rd_bank_q     <= RD_BANK_INIT;
      ready_bank_q  <= 2'd0;
      ready_valid_q <= 1'b0;
      frame_valid_q <= 1'b0;
      wr_load_q     <= 1'b0;
      rd_load_q     <= 1'b0;
      wr_d          <= 1'b1;
      rd_d          <= 1'b1;
      drop_q        <= '0;
      repeat_q      <= '0;
    end else begin
      wr_bank_q     <= wr_bank_n;
      rd_bank_q     <= rd_bank_n;
      ready_bank_q  <= ready_bank_n;
      ready_valid_q <= ready_valid_n;
      frame_valid_q <= frame_valid_n;
      wr_load_q     <= wr_load_n;
      rd_load_q     <= rd_load_n;
      wr_d          <= bus.frame_wr_done;
      rd_d          <= bus.frame_rd_done;
      if (drop_inc && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      if (repeat_inc && repeat_q != '1) repeat_q <= repeat_q + CNT_W'(1);
    end
  end

  assign bus.wr_bank         = wr_bank_q;
  assign bus.rd_bank         = rd_bank_q;
  assign bus.wr_load         = wr_load_q;
  assign bus.rd_load         = rd_load_q;
  assign bus.frame_valid     = frame_valid_q;
  assign bus.drop_cnt        = drop_q;
  assign bus.repeat_cnt      = repeat_q;
  assign bus.dbg_ready_valid = ready_valid_q;
  assign bus.dbg_ready_bank  = ready_bank_q;

  a_banks_differ: assert property (@(posedge DDR_CLK) disable iff (DDR_RST)
    wr_bank_q != rd_bank_q);

  a_ready_distinct: assert property (@(posedge DDR_CLK) disable iff (DDR_RST)
    ready_valid_q |-> (ready_bank_q != wr_bank_q && ready_bank_q != rd_bank_q));

endmodule
